// File: rtl/memory_responder.sv
// Word-addressed 32-bit memory with a MemRead/MemWrite strobe handshake, programmable
// wait states, big-endian sign-extended byte loads and a registered error completion.
module memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        load_byte_i,
  output logic [31:0] read_data_o,
  output logic        mem_ready_o,
  output logic        addr_error_o,
  output logic        busy_o,
  output logic [2:0]  state_o
);

  // Handshake: a request is accepted only in IDLE when mem_read_i or mem_write_i is
  // high at a rising edge; mem_ready_o pulses for one cycle when it completes, with
  // addr_error_o alongside it if the request was rejected. Strobes outside IDLE are ignored.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  lb_q, lb_d;
  logic                  wr_q, wr_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_word;
  logic [7:0]  byte_sel;
  logic        req_err;

  assign ram_word = mem[word_q];

  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0:    byte_sel = ram_word[31:24];
      2'd1:    byte_sel = ram_word[23:16];
      2'd2:    byte_sel = ram_word[15:8];
      default: byte_sel = ram_word[7:0];
    endcase
  end

  // Only a byte read may use a non-zero byte offset.
  assign req_err = (mem_read_i && mem_write_i)
                 || (|addr_i[31:ADDR_WIDTH+2])
                 || ((addr_i[1:0] != 2'b00) && !(mem_read_i && !mem_write_i && load_byte_i));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    lb_d    = lb_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_read_i || mem_write_i) begin
          word_d  = addr_i[ADDR_WIDTH+1:2];
          lane_d  = addr_i[1:0];
          wdata_d = write_data_i;
          lb_d    = load_byte_i;
          wr_d    = mem_write_i;
          if (req_err) begin
            state_d = ERR;
          end else if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        state_d = DONE;
        if (!wr_q) rdata_d = lb_q ? {{24{byte_sel[7]}}, byte_sel} : ram_word;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      word_q  <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      lb_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      lb_q    <= lb_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // An asynchronous reset drops state_q out of ACCESS before the edge, abandoning the write.
  always_ff @(posedge clk_i) begin
    if (state_q == ACCESS && wr_q) mem[word_q] <= wdata_q;
  end

  assign read_data_o  = rdata_q;
  assign mem_ready_o  = (state_q == DONE) || (state_q == ERR);
  assign addr_error_o = (state_q == ERR);
  assign busy_o       = (state_q != IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized scoreboard bench for memory_responder: a word-array reference model predicts
// each completion, and a monitor checks error flag, read data and completion cycle.
module tb_memory_responder;

  localparam int AW = 10;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        rd = 1'b0, wr = 1'b0, lb = 1'b0;
  logic [31:0] read_data;
  logic        mem_ready, addr_error, busy;
  logic [2:0]  state;

  logic [31:0] z_addr = 32'd0, z_wdata = 32'd0;
  logic        z_rd = 1'b0, z_wr = 1'b0, z_lb = 1'b0;
  logic [31:0] z_read_data;
  logic        z_ready, z_err, z_busy;
  logic [2:0]  z_state;

  memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .write_data_i(wdata),
    .mem_read_i(rd), .mem_write_i(wr), .load_byte_i(lb),
    .read_data_o(read_data), .mem_ready_o(mem_ready), .addr_error_o(addr_error),
    .busy_o(busy), .state_o(state)
  );

  memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_z (
    .clk_i(clk), .rst_i(rst), .addr_i(z_addr), .write_data_i(z_wdata),
    .mem_read_i(z_rd), .mem_write_i(z_wr), .load_byte_i(z_lb),
    .read_data_o(z_read_data), .mem_ready_o(z_ready), .addr_error_o(z_err),
    .busy_o(z_busy), .state_o(z_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state and reference model
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem_m [1 << AW];
  logic [31:0] rd_m = 32'd0;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("addr_error", {31'd0, addr_error}, {31'd0, e.err});
          chk("read_data", read_data, e.rdata);
          chk("ready_cycle", cyc, e.cyc);
        end
      end else if (addr_error) begin
        chk("error_without_ready", 32'd1, 32'd0);
      end
    end
  end

  // driver: issues one request, predicts it, then rattles the strobes while busy
  task automatic req(input logic r, input logic w, input logic b,
                     input logic [31:0] a, input logic [31:0] d);
    logic err;
    logic [7:0] byt;
    int lat, busy_cnt;
    bit done;
    @(negedge clk);
    err = (r && w) || (a[31:AW+2] != 0) || (a[1:0] != 2'b00 && !(r && !w && b));
    if (!err) begin
      if (w) begin
        mem_m[a[AW+1:2]] = d;
      end else if (b) begin
        byt  = 8'(mem_m[a[AW+1:2]] >> (8 * (3 - int'(a[1:0]))));
        rd_m = 32'($signed(byt));
      end else begin
        rd_m = mem_m[a[AW+1:2]];
      end
    end
    lat = err ? 1 : WS + 2;
    exp_q.push_back('{err: err, rdata: rd_m, cyc: 32'(cyc + lat)});
    rd = r; wr = w; lb = b; addr = a; wdata = d;
    busy_cnt = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
      end else begin
        busy_cnt++;
        if (mem_ready) begin
          rd = 1'b0; wr = 1'b0;
        end else begin
          rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
          lb = 1'($urandom_range(0, 1));
          addr = $urandom; wdata = $urandom;
        end
      end
    end
    rd = 1'b0; wr = 1'b0;
    if (!done) chk("busy_timeout", 32'd1, 32'd0);
    chk("busy_cycles", 32'(busy_cnt), 32'(lat));
  endtask

  int z_pulses, z_first;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_flags", {29'd0, mem_ready, addr_error, busy}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    rst = 1'b0;

    // fill the working set with known contents
    for (int i = 0; i < 32; i++) req(1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom);

    // word write then read
    req(1'b0, 1'b1, 1'b0, 32'h40, 32'h12345678);
    req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    chk("word_readback", read_data, 32'h12345678);

    // big-endian sign-extended byte loads
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h80F17F01);
    req(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    req(1'b1, 1'b0, 1'b1, 32'h11, 32'h0);
    req(1'b1, 1'b0, 1'b1, 32'h12, 32'h0);
    req(1'b1, 1'b0, 1'b1, 32'h13, 32'h0);
    chk("lb_last", read_data, 32'h00000001);

    // error completions leave RAM and ReadData alone
    req(1'b1, 1'b0, 1'b0, 32'h42, 32'h0);
    req(1'b0, 1'b1, 1'b0, 32'h1000, 32'hCAFEF00D);
    req(1'b1, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D);
    req(1'b0, 1'b1, 1'b1, 32'h41, 32'hCAFEF00D);
    req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);

    // randomized mix
    for (int i = 0; i < 120; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 31) * 4);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'($urandom_range(0, 3));
      if (kind == 0)      req(1'b1, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
      else if (kind == 1) req(1'b1, 1'b0, 1'b0, a | (32'($urandom_range(1, 4095)) << 12), 32'h0);
      else if (kind < 6)  req(1'b1, 1'b0, 1'($urandom_range(0, 1)), a, 32'h0);
      else                req(1'b0, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // reset abort during WAIT of a write
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; lb = 1'b0; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(negedge clk);
    wr = 1'b0;
    chk("abort_in_wait", {29'd0, state}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_flags", {29'd0, mem_ready, addr_error, busy}, 32'd0);
    rd_m = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    req(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);

    // zero-wait instance with a strobe held high continuously
    @(negedge clk);
    z_wr = 1'b1; z_addr = 32'h0; z_wdata = 32'h5A5A5A5A;
    z_pulses = 0;
    z_first = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (z_ready) begin
        z_pulses++;
        if (z_first < 0) z_first = i;
      end
    end
    z_wr = 1'b0;
    chk("ws0_first_ready", 32'(z_first), 32'd1);
    chk("ws0_pulse_count", 32'(z_pulses), 32'd10);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Word-addressed data/instruction memory that services the multicycle controller's memory strobes over a request/ready handshake. Sits between the datapath's address mux (PC or ALU result), register B write data and the controller's MemRead/MemWrite/LoadByte lines. Latches each request, inserts a configurable number of wait states, performs the access, and returns read data with a one-cycle MemReady pulse. Requests that are misaligned, out of range, or contradictory complete with AddrError.

## Interface
- ADDR_WIDTH, 10: word-address bits; depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2: idle cycles inserted before each access; legal range 0..15.

- Clock  input  1  master clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Addr  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word.
- WriteData  input  32  store data.
- MemRead  input  1  read request strobe.
- MemWrite  input  1  write request strobe.
- LoadByte  input  1  qualifies a read as a sign-extended byte load.
- ReadData  output  32  read result; held until the next successful read.
- MemReady  output  1  one-cycle completion pulse.
- AddrError  output  1  one-cycle error flag, coincident with MemReady.
- Busy  output  1  high whenever state is not IDLE.

## Operation
- Reset values: state IDLE, wait counter 0, ReadData 0, MemReady 0, AddrError 0, Busy 0. RAM contents are not reset.
- States: IDLE, WAIT, ACCESS, DONE, ERR.
- IDLE: if MemRead or MemWrite is high at a rising edge, latch Addr, WriteData, LoadByte and the operation type. Strobes are ignored in every other state.
- Error check at acceptance. The request goes to ERR with no RAM access if any of these holds:
  - MemRead and MemWrite are both high;
  - Addr[31:ADDR_WIDTH+2] is non-zero;
  - Addr[1:0] is not 00 and the request is not a byte read (a write, or a read with LoadByte=0).
- Valid request: go to WAIT with counter = WAIT_STATES-1 if WAIT_STATES > 0, else go directly to ACCESS.
- WAIT: decrement the counter each cycle; move to ACCESS on the cycle the counter is 0.
- ACCESS: the RAM operation happens at the rising edge that leaves ACCESS; next state is DONE.
  - Write: RAM[word] = latched WriteData.
  - Word read: ReadData = RAM[word].
  - Byte read: big-endian lane select. Addr[1:0] = 00 selects bits 31:24, 01 → 23:16, 10 → 15:8, 11 → 7:0. ReadData = selected byte sign-extended from bit 7.
- DONE: MemReady = 1 and AddrError = 0; next state IDLE.
- ERR: MemReady = 1 and AddrError = 1; ReadData unchanged; next state IDLE.
- Writes never change ReadData. LoadByte is ignored on writes, apart from the alignment check.

## Timing
- Latency: request sampled in cycle 0 → MemReady high in cycle WAIT_STATES+2.
  - Write data is visible to a read accepted in that write's DONE cycle or later.
- Error latency: MemReady and AddrError high in cycle 1.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after DONE or ERR, at cycle WAIT_STATES+3 at the earliest.
  - A strobe still high in that IDLE cycle is treated as a new request.
  - The requester must drop its strobe in the MemReady cycle.
- Busy rises in cycle 1 and falls in the IDLE cycle after DONE or ERR.
- All outputs are registered; none depends combinationally on the inputs.
- Reset mid-operation (any state): return to IDLE immediately. A write still in WAIT or ACCESS is abandoned and RAM is unchanged. No MemReady is produced for the aborted request.

## Test plan
- Word write then word read, WAIT_STATES=2:
  - write 0x12345678 to Addr 0x40, then read 0x40;
  - ReadData = 0x12345678;
  - each MemReady occurs exactly 4 cycles after its request; AddrError = 0 throughout.
- Byte loads, word 0x80F17F01 at Addr 0x10: LB from 0x10/0x11/0x12/0x13 returns 0xFFFFFF80 / 0xFFFFFFF1 / 0x0000007F / 0x00000001.
- Errors, each in cycle 1 with RAM unchanged:
  - word read at 0x42 → AddrError + MemReady, ReadData keeps its previous value;
  - write at 0x1000 with ADDR_WIDTH=10 → AddrError;
  - MemRead and MemWrite both high → AddrError.
- WAIT_STATES=0: read accepted in cycle 0 → MemReady in cycle 2. A strobe held high continuously produces a MemReady every 3 cycles.
- Reset abort: assert Reset during WAIT of a write of 0xDEADBEEF to 0x20.
  - All outputs return to 0 immediately, with no MemReady.
  - A later read of 0x20 returns the prior contents.
- Strobes asserted during WAIT/ACCESS/DONE are ignored: exactly one MemReady per accepted request, and Busy is high for exactly WAIT_STATES+2 cycles.
